// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding and default sizes shared by the serial add scheduler files.
package serial_add_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
endpackage

// File: rtl/serial_add_scheduler_if.sv
// serial_add_scheduler_if: request/operand and result bus between two requesters and the scheduler.
interface serial_add_scheduler_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             result_valid;
  logic             result_id;
  logic [WIDTH-1:0] result_sum;
  logic             result_cout;
  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, result_valid, result_id, result_sum, result_cout
  );
  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, result_valid, result_id, result_sum, result_cout
  );
endinterface

// File: rtl/serial_add_core.sv
// serial_add_core: bit-serial adder datapath with loadable operand shifters, sum shifter and carry FF.
module serial_add_core
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_nxt_o,
  output logic             cout_o
);
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, s;
  assign s         = a_q[0] ^ b_q[0] ^ carry_q;
  assign cout_o    = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  // sum_nxt_o is the sum register as it will be after this shift, so the final bit can be captured directly
  assign sum_nxt_o = {s, sum_q[WIDTH-1:1]};
  always_comb begin
    a_d     = load_i ? a_i : shift_i ? a_q >> 1 : a_q;
    b_d     = load_i ? b_i : shift_i ? b_q >> 1 : b_q;
    sum_d   = clr_i ? '0 : shift_i ? sum_nxt_o : sum_q;
    carry_d = clr_i ? 1'b0 : shift_i ? cout_o : carry_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end
endmodule

// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler: round-robin arbiter and load/shift/done controller sharing one serial adder.
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic                   clock,
  input logic                   resetn,
  serial_add_scheduler_if.slave bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_id_q, last_id_d, cur_id_q, cur_id_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, id_q, id_d;
  logic             any_req, win_id, last_bit, load, shift, finish;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout;
  assign any_req  = bus.req0 | bus.req1;
  // on a tie the requester that was not served last wins; reset leaves last_id=1 so req0 takes the first tie
  assign win_id   = (bus.req0 & bus.req1) ? ~last_id_q : bus.req1;
  assign last_bit = count_q == CNT_W'(WIDTH - 1);
  serial_add_core #(.WIDTH(WIDTH)) u_core (
    .clock    (clock),
    .resetn   (resetn),
    .load_i   (load),
    .clr_i    (load),
    .shift_i  (shift),
    .a_i      (win_id ? bus.a1 : bus.a0),
    .b_i      (win_id ? bus.b1 : bus.b0),
    .sum_nxt_o(sum_nxt),
    .cout_o   (cout)
  );
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == ST_IDLE  ? (any_req ? ST_SHIFT : ST_IDLE) :
              state_q == ST_SHIFT ? (last_bit ? ST_DONE : ST_SHIFT) : ST_IDLE;
  end
  always_comb begin
    load             = (state_q == ST_IDLE) & any_req;
    shift            = state_q == ST_SHIFT;
    finish           = shift & last_bit;
    bus.busy         = state_q != ST_IDLE;
    bus.result_valid = state_q == ST_DONE;
    bus.gnt0         = gnt0_q;
    bus.gnt1         = gnt1_q;
    bus.result_sum   = sum_q;
    bus.result_cout  = cout_q;
    bus.result_id    = id_q;
  end
  always_comb begin
    count_d   = load ? '0 : shift ? count_q + 1'b1 : count_q;
    last_id_d = load ? win_id : last_id_q;
    cur_id_d  = load ? win_id : cur_id_q;
    gnt0_d    = load & ~win_id;
    gnt1_d    = load & win_id;
    sum_d     = finish ? sum_nxt : sum_q;
    cout_d    = finish ? cout : cout_q;
    id_d      = finish ? cur_id_q : id_q;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      last_id_q <= 1'b1;
      cur_id_q  <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      id_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      last_id_q <= last_id_d;
      cur_id_q  <= cur_id_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      id_q      <= id_d;
    end
  end
endmodule

// File: tb/tb_serial_add_scheduler.sv
// tb_serial_add_scheduler: directed and random checks of the serial add scheduler against an operation-level model.
module tb_serial_add_scheduler;
  localparam int W = 8;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  serial_add_scheduler_if #(.WIDTH(W)) bus ();
  serial_add_scheduler #(.WIDTH(W), .CNT_W(4)) dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;
  int checks = 0, fails = 0;
  int cyc = 0, next_free = 0, acc_edge = -1, ops = 0;
  int w0 = 0, w1 = 0;
  logic m_last = 1'b1, acc_id = 1'b0;
  logic [W:0] acc_val = '0;
  logic [W-1:0] h_sum = '0;
  logic h_cout = 1'b0, h_id = 1'b0;
  logic [W+5:0] exp_vec;
  function automatic logic [W+5:0] obs();
    return {bus.gnt0, bus.gnt1, bus.busy, bus.result_valid, bus.result_id, bus.result_cout, bus.result_sum};
  endfunction
  task automatic model_reset();
    acc_edge = -1; next_free = 0; m_last = 1'b1;
    h_sum = '0; h_cout = 1'b0; h_id = 1'b0; w0 = 0; w1 = 0;
  endtask
  // One clock: an operation occupies the adder for W+2 edges; result appears W edges after acceptance.
  task automatic step();
    @(posedge clock);
    if (cyc >= next_free && (bus.req0 || bus.req1)) begin
      acc_id    = (bus.req0 && bus.req1) ? ~m_last : bus.req1;
      acc_val   = acc_id ? {1'b0, bus.a1} + {1'b0, bus.b1} : {1'b0, bus.a0} + {1'b0, bus.b0};
      acc_edge  = cyc;
      next_free = cyc + W + 2;
      m_last    = acc_id;
      ops++;
    end
    if (acc_edge >= 0 && cyc == acc_edge + W) begin
      {h_cout, h_sum} = acc_val;
      h_id = acc_id;
    end
    exp_vec = {acc_edge >= 0 && cyc == acc_edge && !acc_id,
               acc_edge >= 0 && cyc == acc_edge && acc_id,
               acc_edge >= 0 && cyc >= acc_edge && cyc <= acc_edge + W,
               acc_edge >= 0 && cyc == acc_edge + W,
               h_id, h_cout, h_sum};
    cyc++;
    @(negedge clock);
  endtask
  task automatic test_reset();
    bus.req0 = 0; bus.req1 = 0; bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (obs() !== '0) begin fails++; $display("FAIL reset_outputs got=%h want=0", obs()); end
    resetn = 1'b1;
    model_reset();
    repeat (3) begin
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL reset_idle got=%h want=%h", obs(), exp_vec); end
    end
  endtask
  task automatic test_basic();
    int gc = -1, vc = -1;
    bus.req0 = 1; bus.a0 = 8'h56; bus.b0 = 8'hB2;
    repeat (12) begin
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL basic got=%h want=%h", obs(), exp_vec); end
      if (bus.gnt0) begin gc = cyc; bus.req0 = 0; end
      if (bus.result_valid) vc = cyc;
    end
    checks++;
    if (vc - gc != W) begin fails++; $display("FAIL basic_latency got=%0d want=%0d", vc - gc, W); end
    checks++;
    if ({bus.result_id, bus.result_cout, bus.result_sum} !== 10'h108) begin
      fails++; $display("FAIL basic_result got=%h want=108", {bus.result_id, bus.result_cout, bus.result_sum});
    end
  endtask
  task automatic test_carry_clear();
    int c1 = 0, c2 = 0, ng = 0, nv = 0;
    logic [W:0] r [2];
    r[0] = '1; r[1] = '1;
    bus.req1 = 1; bus.a1 = 8'hFF; bus.b1 = 8'h01;
    repeat (25) begin
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL carry got=%h want=%h", obs(), exp_vec); end
      if (bus.result_valid && nv < 2) begin r[nv] = {bus.result_cout, bus.result_sum}; nv++; end
      if (bus.gnt1) begin
        ng++;
        if (ng == 1) begin c1 = cyc; bus.a1 = 8'h00; bus.b1 = 8'h00; end
        else begin c2 = cyc; bus.req1 = 0; end
      end
    end
    checks++;
    if (c2 - c1 != W + 2) begin fails++; $display("FAIL carry_interval got=%0d want=%0d", c2 - c1, W + 2); end
    checks++;
    if (r[0] !== 9'h100) begin fails++; $display("FAIL carry_first got=%h want=100", r[0]); end
    checks++;
    if (r[1] !== 9'h000) begin fails++; $display("FAIL carry_second got=%h want=000", r[1]); end
  endtask
  task automatic test_alternate();
    int seq [$];
    resetn = 1'b0; @(negedge clock); resetn = 1'b1; model_reset();
    bus.req0 = 1; bus.a0 = 8'($urandom); bus.b0 = 8'($urandom);
    bus.req1 = 1; bus.a1 = 8'($urandom); bus.b1 = 8'($urandom);
    for (int i = 0; i < 60 && seq.size() < 4; i++) begin
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL alternate got=%h want=%h", obs(), exp_vec); end
      if (bus.gnt0) begin seq.push_back(0); bus.a0 = 8'($urandom); bus.b0 = 8'($urandom); end
      if (bus.gnt1) begin seq.push_back(1); bus.a1 = 8'($urandom); bus.b1 = 8'($urandom); end
    end
    bus.req0 = 0; bus.req1 = 0;
    checks++;
    if (seq.size() != 4) begin fails++; $display("FAIL alternate_count got=%0d want=4", seq.size()); end
    for (int i = 0; i < seq.size(); i++) begin
      checks++;
      if (seq[i] != i % 2) begin fails++; $display("FAIL alternate_order idx=%0d got=%0d want=%0d", i, seq[i], i % 2); end
    end
    repeat (12) begin
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL alternate_drain got=%h want=%h", obs(), exp_vec); end
    end
  endtask
  task automatic test_busy_ignore();
    int g1 = -100, g0 = 0;
    bus.req1 = 1; bus.a1 = 8'($urandom); bus.b1 = 8'($urandom);
    repeat (30) begin
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL busy_ignore got=%h want=%h", obs(), exp_vec); end
      if (bus.gnt0) begin g0 = cyc; bus.req0 = 0; end
      if (bus.gnt1) begin g1 = cyc; bus.req1 = 0; bus.req0 = 1; bus.a0 = 8'($urandom); bus.b0 = 8'($urandom); end
    end
    checks++;
    if (g0 - g1 != W + 2) begin fails++; $display("FAIL busy_ignore_gap got=%0d want=%0d", g0 - g1, W + 2); end
  endtask
  task automatic test_reset_mid();
    bus.req0 = 1; bus.a0 = 8'($urandom); bus.b0 = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL reset_mid_pre got=%h want=%h", obs(), exp_vec); end
      if (bus.gnt0) bus.req0 = 0;
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (obs() !== '0) begin fails++; $display("FAIL reset_mid_outputs got=%h want=0", obs()); end
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (12) begin
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL reset_mid_quiet got=%h want=%h", obs(), exp_vec); end
    end
    bus.req0 = 1; bus.a0 = 8'h7F; bus.b0 = 8'h01;
    repeat (12) begin
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL reset_mid_after got=%h want=%h", obs(), exp_vec); end
      if (bus.gnt0) bus.req0 = 0;
    end
    checks++;
    if ({bus.result_id, bus.result_cout, bus.result_sum} !== 10'h080) begin
      fails++; $display("FAIL reset_mid_result got=%h want=080", {bus.result_id, bus.result_cout, bus.result_sum});
    end
  endtask
  task automatic test_random();
    int start = ops, budget = 0;
    bus.req0 = 0; bus.req1 = 0;
    while (ops - start < 500 && budget < 20000) begin
      budget++;
      step(); checks++;
      if (obs() !== exp_vec) begin fails++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs(), exp_vec); end
      if (bus.gnt0) begin w0 = 0; if (bus.req1) w1++; end
      if (bus.gnt1) begin w1 = 0; if (bus.req0) w0++; end
      if (!bus.req0) w0 = 0;
      if (!bus.req1) w1 = 0;
      checks++;
      if (w0 > 1 || w1 > 1) begin fails++; $display("FAIL starvation got=%0d/%0d want<=1", w0, w1); end
      if (bus.gnt0) begin bus.req0 = 1'($urandom); bus.a0 = 8'($urandom); bus.b0 = 8'($urandom); end
      else if (bus.req0) bus.req0 = $urandom_range(15) != 0;
      else if ($urandom_range(2) == 0) begin bus.req0 = 1; bus.a0 = 8'($urandom); bus.b0 = 8'($urandom); end
      if (bus.gnt1) begin bus.req1 = 1'($urandom); bus.a1 = 8'($urandom); bus.b1 = 8'($urandom); end
      else if (bus.req1) bus.req1 = $urandom_range(15) != 0;
      else if ($urandom_range(2) == 0) begin bus.req1 = 1; bus.a1 = 8'($urandom); bus.b1 = 8'($urandom); end
    end
    checks++;
    if (ops - start < 500) begin fails++; $display("FAIL random_budget got=%0d want=500", ops - start); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_carry_clear();
    test_alternate();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/serial_add_scheduler.md
Name: serial_add_scheduler

Overview:
Shares one bit-serial adder datapath between two requesters. Arbitrates round-robin and loads the winner's operands into the operand shift registers. Sequences WIDTH shift cycles with carry clear/propagate, then presents a one-cycle tagged result. Sits between the two requesting blocks and the serial adder core; it replaces the free-running count/done logic with a proper load/shift/done controller.

Parameters:
WIDTH, 8, operand/sum width in bits (≥2)
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W ≥ WIDTH

Ports:
clock  in  1  rising-edge clock
resetn  in  1  reset, asynchronous, active-low
req0  in  1  requester 0 request; level, held until gnt0
a0  in  WIDTH  requester 0 operand A; stable while req0 high
b0  in  WIDTH  requester 0 operand B
req1  in  1  requester 1 request; level, held until gnt1
a1  in  WIDTH  requester 1 operand A
b1  in  WIDTH  requester 1 operand B
gnt0  out  1  one-cycle pulse: requester 0 operands captured
gnt1  out  1  one-cycle pulse: requester 1 operands captured
busy  out  1  high whenever state ≠ IDLE
result_valid  out  1  one-cycle pulse: result fields valid
result_id  out  1  requester index of the completed operation
result_sum  out  WIDTH  A+B modulo 2**WIDTH
result_cout  out  1  carry out of bit WIDTH-1

Behaviour:
- States: IDLE, SHIFT, DONE. All registers are on posedge clock or negedge resetn.
- Reset (async): state=IDLE; count=0; carry FF=0; operand/sum shift registers=0; last_id=1. All outputs 0: gnt0/1, busy, result_valid, result_id, result_sum, result_cout.
- IDLE arbitration at each edge:
  - No req: stay in IDLE.
  - Exactly one req: that requester wins.
  - Both req: winner = !last_id (round-robin). After reset, req0 wins the first tie.
- Accept edge (IDLE→SHIFT):
  - Load winner's A/B into the operand shift registers.
  - Clear the carry FF and the sum register; count=0.
  - Record the winner in cur_id and last_id.
  - gnt<winner> is registered: high for exactly the cycle after the accept edge.
- SHIFT, each edge:
  - Full adder on a[0], b[0], carry.
  - Sum bit shifts in at MSB of the sum register (right shift); operands shift right with 0 fill.
  - Carry FF takes cout.
  - count++.
  - At the edge where count==WIDTH-1 (the WIDTH-th shift): go to DONE. Load result_sum from the final sum register contents including this bit, result_cout from this cout, result_id=cur_id.
- DONE: result_valid=1 for exactly one cycle; next edge → IDLE.
- Latency and throughput:
  - result_valid is high during the cycle after edge accept+WIDTH.
  - Back-to-back operations: next accept happens at the edge leaving DONE+1 (IDLE edge). Issue interval is WIDTH+2 cycles.
- Hold rules:
  - result_sum, result_cout and result_id hold their values after the valid pulse until the next DONE load.
  - req/operands are ignored outside IDLE. A requester that drops req before its gnt simply is not served.
  - A requester re-asserting req in the cycle after its own gnt is legal; it competes normally.
- Carry never leaks between operations: cleared on every accept.
- Reset mid-operation: in-flight operation is discarded, no result_valid, no late gnt. First post-reset tie goes to req0.
- Width rule: result_sum = (A+B)[WIDTH-1:0]; result_cout = (A+B)[WIDTH].

Decomposition:
- Package serial_add_pkg:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - default WIDTH=8 and CNT_W=4 constants
- Sub-module serial_add_core:
  - two operand right-shift registers with parallel load, sum right-shift register, carry FF, full adder
  - controls: load, shift, clr
  - scheduler holds the FSM, arbiter, counter and result registers

Test Plan:
- req0=1, a0=0x56, b0=0xB2 → gnt0 pulse 1 cycle after accept; result_valid 8 cycles after accept edge; result_sum=0x08, result_cout=1, result_id=0.
- req1=1, a1=0xFF, b1=0x01, then a1=0x00, b1=0x00 → first result 0x00/cout=1; second 0x00/cout=0, proving carry cleared; issue interval = 10 cycles.
- req0 and req1 held high continuously with distinct operands → grants alternate 0,1,0,1 starting with 0; result_id matches; each sum correct.
- req0 asserted while busy with requester-1 operation → ignored until IDLE; then gnt0, correct sum.
- resetn low 4 cycles into SHIFT → all outputs 0 immediately; no result_valid or gnt follows; new req0 with 0x7F+0x01 → 0x80, cout=0.
- Random 500 operations with random req patterns → every accepted operation yields exactly one result_valid with matching id; sum/cout match reference model; no starvation (no requester waits >1 operation).
